pulse_train_gen: RTL and testbench

Programmable pulse-train generator: the transmit-side counterpart of the edge detectors. A one-cycle `start` strobe launches a train of `num_pulses` pulses on `signal_out`. Each pulse is `high_len` cycles active, followed by `low_len` cycles inactive. The block supplies known rising and falling edges to downstream edge-detection logic, and serves as stimulus/control for it. It reports `busy`, a one-cycle `done`, and a running count of completed pulses.

---
 rtl/pulse_train_gen.sv | 121 ++++++++++++
 tb/tb_pulse_train_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: programmable pulse-train generator with busy/done/pulse count
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       launch strobe, accepted only in IDLE and only without stop
//   stop        abort request, honoured in any state
//   high_len    active-phase length in cycles (0 behaves as 1), latched on launch
//   low_len     inactive-phase length in cycles (0 behaves as 1), latched on launch
//   num_pulses  pulses per train, latched on launch; 0 runs until stop
//   signal_out  registered waveform
//   busy        high while a train runs (HIGH or LOW state)
//   done        one-cycle strobe on normal completion
//   pulse_cnt   completed active phases in the current or last train, saturating
//
// Build option: PULSE_TRAIN_ACTIVE_LOW_EN makes signal_out idle high and pulse low.
module pulse_train_gen #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             signal_out,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_cnt
);

`ifdef PULSE_TRAIN_ACTIVE_LOW_EN
    localparam logic ACT = 1'b0;
`else
    localparam logic ACT = 1'b1;
`endif

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] h_len;
    logic [CNT_W-1:0] l_len;
    logic [NUM_W-1:0] n_lat;

    // The phase counter counts down to zero, so a phase of length v loads v-1;
    // a zero length loads zero and therefore still lasts one cycle.
    function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            h_len      <= '0;
            l_len      <= '0;
            n_lat      <= '0;
            pulse_cnt  <= '0;
            signal_out <= ~ACT;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state      <= IDLE;
                signal_out <= ~ACT;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state      <= HIGH;
                            h_len      <= high_len;
                            l_len      <= low_len;
                            n_lat      <= num_pulses;
                            pulse_cnt  <= '0;
                            cnt        <= ld(high_len);
                            signal_out <= ACT;
                            busy       <= 1'b1;
                        end
                    end
                    HIGH: begin
                        if (cnt == '0) begin
                            state      <= LOW;
                            cnt        <= ld(l_len);
                            signal_out <= ~ACT;
                            pulse_cnt  <= (&pulse_cnt) ? pulse_cnt : pulse_cnt + NUM_W'(1);
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    LOW: begin
                        if (cnt == '0) begin
                            // pulse_cnt already includes the pulse just finished
                            if (n_lat == '0 || pulse_cnt != n_lat) begin
                                state      <= HIGH;
                                cnt        <= ld(h_len);
                                signal_out <= ACT;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        signal_out <= ~ACT;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: directed vector bench for pulse_train_gen
module tb_pulse_train_gen;

`ifdef PULSE_TRAIN_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] high_len = '0;
    logic [7:0] low_len = '0;
    logic [7:0] num_pulses = '0;
    logic       signal_out;
    logic       busy;
    logic       done;
    logic [7:0] pulse_cnt;

    int checks = 0;
    int failures = 0;

    pulse_train_gen dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .high_len(high_len),
        .low_len(low_len),
        .num_pulses(num_pulses),
        .signal_out(signal_out),
        .busy(busy),
        .done(done),
        .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       sp;
        logic [7:0] h;
        logic [7:0] l;
        logic [7:0] n;
        logic       sig;
        logic       bsy;
        logic       dn;
        logic [7:0] cnt;
    } vec_t;

    vec_t v[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic outs(input string tag, input logic s, input logic b, input logic d, input logic [7:0] c);
        chk({tag, ".signal_out"}, 32'(signal_out), 32'(s ^ INV));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".pulse_cnt"}, 32'(pulse_cnt), 32'(c));
    endtask

    task automatic drive(input logic st, input logic sp, input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
        start = st;
        stop = sp;
        high_len = h;
        low_len = l;
        num_pulses = n;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    initial begin
        // basic train H3 L2 N2, ignored start mid-train, start in done cycle,
        // start+stop in IDLE, zero lengths H0 L0 N3
        v[0]  = '{1'b1, 1'b0, 8'd3, 8'd2, 8'd2, 1'b1, 1'b1, 1'b0, 8'd0};
        v[1]  = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0};
        v[2]  = '{1'b1, 1'b0, 8'd7, 8'd7, 8'd5, 1'b1, 1'b1, 1'b0, 8'd0};
        v[3]  = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd1};
        v[4]  = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd1};
        v[5]  = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd1};
        v[6]  = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd1};
        v[7]  = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd1};
        v[8]  = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd2};
        v[9]  = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd2};
        v[10] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2};
        v[11] = '{1'b1, 1'b0, 8'd1, 8'd1, 8'd1, 1'b1, 1'b1, 1'b0, 8'd0};
        v[12] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd1};
        v[13] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1};
        v[14] = '{1'b1, 1'b1, 8'd5, 8'd5, 8'd5, 1'b0, 1'b0, 1'b0, 8'd1};
        v[15] = '{1'b1, 1'b0, 8'd0, 8'd0, 8'd3, 1'b1, 1'b1, 1'b0, 8'd0};
        v[16] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd1};
        v[17] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd1};
        v[18] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd2};
        v[19] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd2};
        v[20] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd3};
        v[21] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd3};
        v[22] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd3};

        #1;
        outs("reset", 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        tick();
        outs("idle", 1'b0, 1'b0, 1'b0, 8'd0);

        for (int k = 0; k < 23; k++) begin
            drive(v[k].st, v[k].sp, v[k].h, v[k].l, v[k].n);
            @(posedge clk);
            #1;
            outs($sformatf("vec%0d", k), v[k].sig, v[k].bsy, v[k].dn, v[k].cnt);
        end

        // continuous train H2 L2, stop in 2nd cycle of the 3rd active phase
        drive(1'b1, 1'b0, 8'd2, 8'd2, 8'd0);
        tick();
        repeat (9) tick();
        outs("cont_pre_stop", 1'b1, 1'b1, 1'b0, 8'd2);
        stop = 1'b1;
        tick();
        outs("cont_stop", 1'b0, 1'b0, 1'b0, 8'd2);
        for (int k = 0; k < 3; k++) begin
            tick();
            outs($sformatf("cont_after%0d", k), 1'b0, 1'b0, 1'b0, 8'd2);
        end

        // asynchronous reset in cycle 6 of an H4 L4 train
        drive(1'b1, 1'b0, 8'd4, 8'd4, 8'd3);
        tick();
        repeat (5) tick();
        outs("rst_pre", 1'b0, 1'b1, 1'b0, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        outs("rst_async", 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        outs("rst_after", 1'b0, 1'b0, 1'b0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
